ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter for the keyboard piano.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs followed by the LED mask, or 0xFF reset.
- Drives the open-collector PS/2 clock and data lines through output-enable pins and follows the device-generated clock bit by bit.
- Runs beside the PS/2 receiver on the same two lines. The receiver must ignore line activity while this block's tx_busy is high.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks that ps2 clock is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum system clocks allowed between PS/2 clock falling edges (15 ms) before the transfer aborts.
- CNT_W, 20: width of the shared inhibit/timeout counter. Must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- ps2_clk_in, input, 1: raw PS/2 clock line, asynchronous to clk.
- ps2_data_in, input, 1: raw PS/2 data line, asynchronous to clk.
- ps2_clk_oe, output, 1: 1 pulls the PS/2 clock line low; 0 releases it.
- ps2_data_oe, output, 1: 1 pulls the PS/2 data line low; 0 releases it.
- tx_data, input, 8: byte to send.
- tx_valid, input, 1: request to send tx_data.
- tx_ready, output, 1: block is idle and accepts a request.
- tx_busy, output, 1: a transfer is in progress.
- tx_done, output, 1: one-cycle pulse when the device acknowledges.
- tx_error, output, 1: one-cycle pulse on timeout or missing acknowledge.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters=0. tx_ready=1 (decoded from IDLE).
- Reset mid-transfer releases both lines immediately (asynchronously) and discards the byte.
- Input synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser.
- Falling-edge detect: fall = prev_sync_clk & ~sync_clk. A falling edge is acted on 3 clk cycles after the raw line falls.
- Handshake: a transfer is accepted on a rising clk edge where tx_valid & tx_ready.
  - On accept: latch tx_data into a shift register and compute parity = ~^tx_data (odd parity).
  - tx_ready falls and tx_busy rises the next cycle.
  - tx_valid while busy is ignored. There is no queue.
- INHIBIT: ps2_clk_oe=1, data released. Count INHIBIT_CYCLES, then go to START.
- START: ps2_data_oe=1 (start bit 0) while ps2_clk_oe stays 1 for exactly 1 cycle. Then ps2_clk_oe=0, clear the timeout counter, go to SHIFT with bit index = 0.
- SHIFT: on each fall, drive the next bit and increment the index.
  - Bits are driven as ps2_data_oe = ~bit.
  - Order: d0..d7 on falls 1-8, parity on fall 9, stop (ps2_data_oe=0) on fall 10.
  - After fall 10, go to ACK.
- ACK: on fall 11, sample the synchronised data line.
  - Data = 0: acknowledge. Go to WAIT_IDLE.
  - Data = 1: no acknowledge. Pulse tx_error, go to IDLE.
- WAIT_IDLE: wait for synchronised clock = 1 and data = 1, then pulse tx_done and go to IDLE.
- Timeout: in SHIFT, ACK and WAIT_IDLE, the timeout counter clears on every fall and otherwise increments.
  - Reaching TIMEOUT_CYCLES pulses tx_error, releases both lines and goes to IDLE.
  - This also covers a device that never starts clocking after the start bit.
- Pulse timing: tx_done and tx_error are registered, high for exactly 1 cycle, and mutually exclusive.
  - tx_ready is 1 in the same cycle as either pulse, so a back-to-back accept is allowed.
- Line safety: ps2_clk_oe is never 1 outside INHIBIT and START. ps2_data_oe is 0 in IDLE, ACK and WAIT_IDLE.
- Simultaneous events: a timeout and a fall in the same cycle resolve in favour of the fall.

Test Plan (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64, PS/2 device model clocking at 1 edge per 10 clk):
- Send 0xED, device acks:
  - ps2_clk_oe high for 8 cycles, then data low with clock released.
  - Data sequence observed at device rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once, tx_error stays 0, tx_ready returns to 1.
- Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. Both complete with tx_done.
- Device leaves data high at fall 11 (no ack) -> tx_error pulse, no tx_done, both oe = 0, state IDLE.
- Device stops clocking after fall 4 -> tx_error exactly 64 cycles after the last detected fall, lines released.
- Assert reset_n=0 during SHIFT bit 5 -> both oe drop to 0 without waiting for clk. After release, tx_ready=1 and a fresh 0xFF transfer completes.
- tx_valid held high with a new byte during a transfer -> ignored. A second byte 0x02 is accepted in the tx_done cycle and sent next, with the inhibit phase starting the following cycle.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 transmitter. Inhibits the bus, issues a
//            request-to-send, then shifts out one byte (LSB first, odd parity,
//            stop) on the device-generated clock and checks the acknowledge.
// Ports    : clk, reset_n            - system clock, async active-low reset
//            ps2_clk_in, ps2_data_in - raw (asynchronous) PS/2 line levels
//            ps2_clk_oe, ps2_data_oe - 1 pulls the corresponding line low
//            tx_data, tx_valid       - byte to send and send request
//            tx_ready, tx_busy       - idle / transfer-in-progress status
//            tx_done, tx_error       - one-cycle completion / failure pulses
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_START     = 3'd2,
      S_SHIFT     = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] c_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_clk_s1, r_clk_s2, r_clk_prev;
   logic             r_dat_s1, r_dat_s2;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_shift;
   logic             r_parity;
   logic [3:0]       r_idx;
   logic             r_data_oe;
   logic             r_done;
   logic             r_err;

   logic             w_fall;
   logic             w_timeout;
   logic             w_accept;
   logic             w_cnt_clr;
   logic             w_cnt_inc;
   logic             w_bit_step;
   logic             w_done_set;
   logic             w_err_set;

   // Two-flop synchronisers plus one history flop for edge detection.
   // Reset to 1 (idle bus level) so no false falling edge follows reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= ps2_clk_in;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= ps2_data_in;
         r_dat_s2   <= r_dat_s1;
      end
   end

   assign w_fall    = r_clk_prev & ~r_clk_s2;
   assign w_timeout = (r_cnt == c_TMO_LAST);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and output decode. A fall always takes priority over a
   // timeout that matures in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_bit_step  = 1'b0;
      w_done_set  = 1'b0;
      w_err_set   = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      tx_ready    = 1'b0;
      tx_busy     = 1'b1;

      case (r_state)
         S_IDLE: begin
            tx_ready = 1'b1;
            tx_busy  = 1'b0;
            if (tx_valid) begin
               w_accept    = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (r_cnt == c_INH_LAST) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_START;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_START: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            ps2_data_oe = r_data_oe;
            if (w_fall) begin
               w_bit_step = 1'b1;
               w_cnt_clr  = 1'b1;
               if (r_idx == 4'd9) w_state_nxt = S_ACK;
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_ACK: begin
            if (w_fall) begin
               w_cnt_clr = 1'b1;
               if (r_dat_s2) begin
                  w_err_set   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_WAIT_IDLE;
               end
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (r_clk_s2 && r_dat_s2) begin
               w_done_set  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_fall) begin
               w_cnt_clr = 1'b1;
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: shared counter, shift register, bit index, data drive, pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_idx     <= '0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= w_done_set;
         r_err  <= w_err_set;

         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

         if (w_accept) begin
            r_shift  <= tx_data;
            r_parity <= ~^tx_data;
         end

         // START hands over to SHIFT still holding the start bit (line low).
         if (r_state == S_START) begin
            r_data_oe <= 1'b1;
            r_idx     <= '0;
         end else if (w_bit_step) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx < 4'd8) begin
               r_data_oe <= ~r_shift[0];
               r_shift   <= {1'b0, r_shift[7:1]};
            end else if (r_idx == 4'd8) begin
               r_data_oe <= ~r_parity;
            end else begin
               r_data_oe <= 1'b0;
            end
         end
      end
   end

   assign tx_done  = r_done;
   assign tx_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with a PS/2 device model
//            (open-collector lines, 10 clk per device clock period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
   localparam int INH = 8;
   localparam int TMO = 64;
   localparam int CW  = 20;

   typedef struct {
      logic [7:0] data;
      int         falls;     // device clock falls produced (11 = full frame)
      bit         ack;       // device pulls data low for fall 11
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_done, tx_error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
   int last_err_cyc = 0;
   int last_fall = 0;
   logic prev_done = 1'b0, prev_err = 1'b0;
   logic oe_bad = 1'b0;

   always #5 clk = ~clk;

   // Open-collector bus: released lines float high.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor
   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      if (tx_done && tx_error) overlap_cnt++;
      if ((tx_done && prev_done) || (tx_error && prev_err)) wide_cnt++;
      prev_done = tx_done;
      prev_err  = tx_error;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      int ones = 0;
      logic p;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      p = ((ones % 2) == 0);
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!tx_ready && n < 200) begin
         n++;
         tick();
      end
      chk("ready_wait", {31'd0, tx_ready}, 32'd1);
   endtask

   // Called on the first cycle after acceptance.
   task automatic check_request();
      int n = 0;
      chk("busy_after_accept", {30'd0, tx_busy, tx_ready}, 32'h2);
      while (ps2_clk_oe && !ps2_data_oe && n < 50) begin
         n++;
         tick();
      end
      chk("inhibit_len", n, INH);
      chk("start_cycle_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h3);
      tick();
      chk("clk_released_data_low", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h1);
   endtask

   task automatic device(input logic [10:0] exp, input int falls, input bit ack);
      logic [10:0] got = '0;
      int mask;
      oe_bad = 1'b0;
      got[0] = ps2_data_in;
      repeat (3) tick();
      for (int k = 1; k <= 10; k++) begin
         if (k > falls) break;
         dev_clk_low = 1'b1;
         last_fall = cyc;
         repeat (5) tick();
         got[k] = ps2_data_in;
         oe_bad = oe_bad | ps2_clk_oe;
         dev_clk_low = 1'b0;
         repeat (5) tick();
         oe_bad = oe_bad | ps2_clk_oe;
      end
      if (falls >= 11) begin
         dev_data_low = ack;
         repeat (2) tick();
         chk("ack_phase_data_oe", {31'd0, ps2_data_oe}, 32'd0);
         dev_clk_low = 1'b1;
         last_fall = cyc;
         repeat (5) tick();
         dev_clk_low  = 1'b0;
         dev_data_low = 1'b0;
      end
      mask = (falls >= 10) ? 32'h7FF : ((1 << (falls + 1)) - 1);
      chk("frame_bits", 32'(got) & mask, 32'(exp) & mask);
      chk("clk_oe_while_device_clocks", {31'd0, oe_bad}, 32'd0);
   endtask

   task automatic wait_end(input int sd, input int se);
      int n = 0;
      while (done_cnt == sd && err_cnt == se && n < 300) begin
         n++;
         tick();
      end
      repeat (3) tick();
   endtask

   task automatic run_vec(input vec_t v);
      int sd = done_cnt;
      int se = err_cnt;
      wait_ready();
      tx_data  = v.data;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check_request();
      device(model_frame(v.data), v.falls, v.ack);
      wait_end(sd, se);
      chk("done_pulses", done_cnt - sd, v.exp_done ? 1 : 0);
      chk("error_pulses", err_cnt - se, v.exp_err ? 1 : 0);
      chk("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      chk("idle_status", {30'd0, tx_ready, tx_busy}, 32'h2);
      if (v.falls < 11)
         chk("timeout_delay", last_err_cyc - last_fall, TMO + 3);
   endtask

   vec_t tbl[8];

   initial begin
      logic [7:0] r;
      int sd, se, n;

      tbl[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{8'h07, 11, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 11, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{8'h5A, 11, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'hA3,  4, 1'b1, 1'b0, 1'b1};
      for (int i = 5; i < 8; i++) begin
         r = 8'($urandom);
         tbl[i] = '{r, 11, 1'b1, 1'b1, 1'b0};
         if ($urandom_range(0, 1) == 0) begin
            tbl[i].ack = 1'b0;
            tbl[i].exp_done = 1'b0;
            tbl[i].exp_err = 1'b1;
         end
      end

      // Reset state
      repeat (3) tick();
      chk("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      chk("reset_status", {28'd0, tx_ready, tx_busy, tx_done, tx_error}, 32'h8);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // tx_valid held with another byte during a transfer is ignored; a new
      // byte offered in the tx_done cycle is taken immediately.
      wait_ready();
      sd = done_cnt;
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      tick();
      tx_data = 8'h55;
      check_request();
      device(model_frame(8'h11), 11, 1'b1);
      n = 0;
      while (!tx_done && n < 50) begin
         n++;
         tick();
      end
      chk("b2b_done_ready", {30'd0, tx_done, tx_ready}, 32'h3);
      tx_data = 8'h02;
      tick();
      tx_valid = 1'b0;
      chk("b2b_inhibit_next_cycle", {31'd0, ps2_clk_oe}, 32'd1);
      se = err_cnt;
      check_request();
      device(model_frame(8'h02), 11, 1'b1);
      wait_end(sd + 1, se);
      chk("b2b_done_pulses", done_cnt - sd, 2);
      chk("b2b_error_pulses", err_cnt - se, 0);

      // Asynchronous reset in the middle of SHIFT (while bit d5 is driven).
      wait_ready();
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check_request();
      device(model_frame(8'h3C), 6, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("after_reset_status", {28'd0, tx_ready, tx_busy, tx_done, tx_error}, 32'h8);
      run_vec('{8'hFF, 11, 1'b1, 1'b1, 1'b0});

      chk("pulse_overlap", overlap_cnt, 0);
      chk("pulse_width", wide_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
